rv32i_apb_bridge: RTL and testbench
===================================

RV32I_APB_BRIDGE -- requirements
Module: rv32i_apb_bridge

Interface
REQ-001 The block SHALL have parameter NSLV, default 4, giving the number of APB slave selects.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum ACCESS-phase wait cycles before abort.
REQ-003 The block SHALL have parameter BASE_HI, default 16'h1000, giving the required value of dAddr[31:16] for a bridge hit.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 d_req  in  1  core data access request; held with all fields stable until d_done.
REQ-007 d_wr_en  in  1  1 = store, 0 = load.
REQ-008 dAddr  in  32  byte address.
REQ-009 dWdata  in  32  store data, LSB-aligned.
REQ-010 d_func3  in  3  RV32I load/store width code.
REQ-011 dRdata  out  32  load result, extended per d_func3, registered.
REQ-012 d_done  out  1  one-cycle completion pulse.
REQ-013 d_err  out  1  valid with d_done; decode, misalign, slave or timeout error.
REQ-014 PSEL  out  NSLV  one-hot APB slave select.
REQ-015 PENABLE, PWRITE  out  1 each  APB phase and direction.
REQ-016 PADDR  out  32  word-aligned address (dAddr with [1:0] = 0).
REQ-017 PWDATA  out  32  byte-lane-replicated store data.
REQ-018 PSTRB  out  4  byte strobes; 0 on reads.
REQ-019 PRDATA  in  32; PREADY, PSLVERR  in  1 each  slave response.

Function
REQ-020 FSM states: IDLE, SETUP, ACCESS, DONE; requests are accepted only in IDLE.
REQ-021 IDLE with d_req=1: a hit (dAddr[31:16]=BASE_HI, dAddr[15:12]<NSLV, aligned) SHALL go to SETUP; otherwise go to DONE with d_err=1 and no APB activity.
REQ-022 Alignment: halfword requires dAddr[0]=0; word requires dAddr[1:0]=0; func3 3, 6 or 7 SHALL be a misalign/illegal error.
REQ-023 SETUP: PSEL[dAddr[15:12]]=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB driven; next state is ACCESS.
REQ-024 ACCESS: PENABLE=1, all APB outputs held; on PREADY=1 capture PRDATA and PSLVERR, then go to DONE.
REQ-025 Wait counter: cleared on entering ACCESS, incremented per cycle with PREADY=0; when it reaches TIMEOUT, go to DONE with d_err=1 and drop PSEL.
REQ-026 DONE: d_done=1 for exactly one cycle, PSEL=0, PENABLE=0; next state is IDLE.
REQ-027 Minimum latency: request sampled in IDLE at cycle n, PREADY=1 at n+2, d_done at n+3; back-to-back throughput is one access per 4 cycles.
REQ-028 Strobes: SB = 4'b0001<<dAddr[1:0]; SH = 4'b0011<<dAddr[1:0]; SW = 4'b1111.
REQ-029 PWDATA: SB replicates the byte to 4 lanes, SH replicates the halfword to 2 lanes, SW passes through.
REQ-030 Loads: select lane by dAddr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-031 dRdata SHALL be 0 on stores and on any error.
REQ-032 dRdata holds its value until the next d_done.
REQ-033 A d_req deassertion mid-transaction SHALL be ignored; the transaction completes normally.
REQ-034 PSLVERR is sampled only when PREADY=1.

Reset
REQ-035 On reset, the state SHALL go to IDLE and the wait counter to 0.
REQ-036 On reset, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, dRdata, d_done and d_err SHALL all be 0.
REQ-037 Reset asserted mid-transaction SHALL abandon the transfer the next edge, with no d_done.

Structure
REQ-038 Package rv32i_bus_pkg SHALL hold the state enum, the funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW) and the BASE_HI default.
REQ-039 Sub-module rv32i_lsu_align SHALL be combinational and hold the strobe, replication and load-extension logic.

Verification
REQ-040 LW from 0x1000_1004, PRDATA=0xDEADBEEF, PREADY at first ACCESS: PSEL=4'b0010, d_done 3 cycles after request, dRdata=0xDEADBEEF, d_err=0.
REQ-041 LB from 0x1000_0003, PRDATA=0x80xxxxxx: dRdata=0xFFFFFF80; LBU from the same address: dRdata=0x00000080.
REQ-042 SH dWdata=0x1234 to 0x1000_2002: PSTRB=4'b1100, PWDATA=0x12341234, PWRITE=1.
REQ-043 LW from 0x1000_0002 and LW from 0x2000_0000: d_done and d_err next cycle, PSEL stays 0.
REQ-044 PREADY held 0: d_err=1 after exactly TIMEOUT ACCESS cycles; with PSLVERR=1 on PREADY, d_err=1 and dRdata=0.
REQ-045 Reset asserted during ACCESS: all outputs 0 next cycle, no d_done; a following LW completes normally.

Source files
------------

// File: rtl/rv32i_bus_pkg.sv
// Shared types and constants for the RV32I data-side APB bridge.
package rv32i_bus_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} bus_state_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [15:0] BASE_HI_DEFAULT = 16'h1000;

  // Codes 3, 6 and 7 have no RV32I load/store meaning and are always rejected.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = off[0];
      F3_LW:         bad = |off;
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rv32i_lsu_align.sv
// Byte-lane handling for the bridge: store strobes/replication and load extraction/extension.
module rv32i_lsu_align
  import rv32i_bus_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  strb,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] lane;

  always_comb begin
    misalign = is_misaligned(func3, byte_off);

    case (func3[1:0])
      2'd0: begin
        strb        = 4'b0001 << byte_off;
        wdata_lanes = {4{wdata[7:0]}};
      end
      2'd1: begin
        strb        = 4'b0011 << byte_off;
        wdata_lanes = {2{wdata[15:0]}};
      end
      default: begin
        strb        = 4'b1111;
        wdata_lanes = wdata;
      end
    endcase

    lane = rdata >> {byte_off, 3'b000};
    case (func3)
      F3_LB:   rdata_ext = {{24{lane[7]}}, lane[7:0]};
      F3_LBU:  rdata_ext = {24'h0, lane[7:0]};
      F3_LH:   rdata_ext = {{16{lane[15]}}, lane[15:0]};
      F3_LHU:  rdata_ext = {16'h0, lane[15:0]};
      default: rdata_ext = lane;
    endcase
  end

endmodule

// File: rtl/rv32i_apb_bridge.sv
// Core data-port to APB master bridge: decode, one APB transfer per request, timeout abort.
module rv32i_apb_bridge
  import rv32i_bus_pkg::*;
#(
  parameter int unsigned NSLV    = 4,
  parameter int unsigned TIMEOUT = 255,
  parameter logic [15:0] BASE_HI = BASE_HI_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            d_req,
  input  logic            d_wr_en,
  input  logic [31:0]     dAddr,
  input  logic [31:0]     dWdata,
  input  logic [2:0]      d_func3,
  output logic [31:0]     dRdata,
  output logic            d_done,
  output logic            d_err,
  output logic [NSLV-1:0] PSEL,
  output logic            PENABLE,
  output logic            PWRITE,
  output logic [31:0]     PADDR,
  output logic [31:0]     PWDATA,
  output logic [3:0]      PSTRB,
  input  logic [31:0]     PRDATA,
  input  logic            PREADY,
  input  logic            PSLVERR
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  bus_state_e     state;
  logic [CW-1:0]  wait_cnt;
  logic [2:0]     func3_q;
  logic [1:0]     off_q;
  logic [2:0]     al_func3;
  logic [1:0]     al_off;
  logic [3:0]     al_strb;
  logic [31:0]    al_wdata;
  logic [31:0]    al_rdata;
  logic           al_misalign;
  logic           hit;
  logic [NSLV-1:0] sel_onehot;

  // One aligner serves both directions: live request fields while decoding in
  // IDLE, the latched width/offset once the transfer is under way.
  always_comb begin
    al_func3   = (state == IDLE) ? d_func3 : func3_q;
    al_off     = (state == IDLE) ? dAddr[1:0] : off_q;
    hit        = (dAddr[31:16] == BASE_HI) && (32'(dAddr[15:12]) < NSLV) && !al_misalign;
    sel_onehot = NSLV'(1) << dAddr[15:12];
  end

  rv32i_lsu_align u_align (
    .func3       (al_func3),
    .byte_off    (al_off),
    .wdata       (dWdata),
    .rdata       (PRDATA),
    .strb        (al_strb),
    .wdata_lanes (al_wdata),
    .rdata_ext   (al_rdata),
    .misalign    (al_misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      func3_q  <= '0;
      off_q    <= '0;
      PSEL     <= '0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      PSTRB    <= '0;
      dRdata   <= '0;
      d_done   <= 1'b0;
      d_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req) begin
            func3_q <= d_func3;
            off_q   <= dAddr[1:0];
            if (hit) begin
              PSEL   <= sel_onehot;
              PWRITE <= d_wr_en;
              PADDR  <= {dAddr[31:2], 2'b00};
              PWDATA <= al_wdata;
              PSTRB  <= d_wr_en ? al_strb : '0;
              state  <= SETUP;
            end else begin
              d_done <= 1'b1;
              d_err  <= 1'b1;
              dRdata <= '0;
              state  <= DONE;
            end
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            d_done  <= 1'b1;
            d_err   <= PSLVERR;
            dRdata  <= (PWRITE || PSLVERR) ? '0 : al_rdata;
            state   <= DONE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            d_done  <= 1'b1;
            d_err   <= 1'b1;
            dRdata  <= '0;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE: begin
          d_done <= 1'b0;
          d_err  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_apb_bridge.sv
// Scoreboard bench for rv32i_apb_bridge: directed cases plus randomized traffic against a byte-level model.
module tb_rv32i_apb_bridge;
  import rv32i_bus_pkg::*;

  localparam int unsigned NSLV = 4;
  localparam int unsigned TMO  = 12;

  logic            clk = 1'b0;
  logic            reset;
  logic            d_req;
  logic            d_wr_en;
  logic [31:0]     dAddr;
  logic [31:0]     dWdata;
  logic [2:0]      d_func3;
  logic [31:0]     dRdata;
  logic            d_done;
  logic            d_err;
  logic [NSLV-1:0] PSEL;
  logic            PENABLE;
  logic            PWRITE;
  logic [31:0]     PADDR;
  logic [31:0]     PWDATA;
  logic [3:0]      PSTRB;
  logic [31:0]     PRDATA;
  logic            PREADY;
  logic            PSLVERR;

  always #5 clk = ~clk;

  rv32i_apb_bridge #(.NSLV(NSLV), .TIMEOUT(TMO), .BASE_HI(16'h1000)) dut (
    .clk(clk), .reset(reset), .d_req(d_req), .d_wr_en(d_wr_en), .dAddr(dAddr),
    .dWdata(dWdata), .d_func3(d_func3), .dRdata(dRdata), .d_done(d_done),
    .d_err(d_err), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        apb;
    logic [3:0]  psel;
    logic        pwrite;
    logic [31:0] paddr;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    int          lat;
    int          acc;
    int          start;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          s_delay = 0;
  int          s_cnt   = 0;
  logic [31:0] s_prd   = '0;
  logic        s_slverr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference model: decode, lane math and sign extension done with plain arithmetic.
  function automatic exp_t model(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [2:0] f3, input logic [31:0] prd, input int delay,
                                 input logic serr);
    exp_t   e;
    int     nb;
    int     off;
    int     slot;
    longint v;
    bit     illegal;
    bit     hit;
    e = '{default: 0};
    nb   = 1 << f3[1:0];
    off  = int'(addr % 4);
    slot = int'((addr / 4096) % 16);
    illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || ((addr % nb) != 0);
    hit = !illegal && ((addr / 65536) == 32'h1000) && (slot < NSLV);
    if (!hit) begin
      e.err = 1'b1;
      e.lat = 1;
      return e;
    end
    e.apb    = 1'b1;
    e.psel   = 4'(1 << slot);
    e.pwrite = wr;
    e.paddr  = addr - off;
    if (delay < int'(TMO)) begin
      e.acc = delay + 1;
      e.err = serr;
    end else begin
      e.acc = TMO;
      e.err = 1'b1;
    end
    e.lat = 2 + e.acc;
    if (wr) begin
      e.pstrb = 4'(((1 << nb) - 1) << off);
      case (nb)
        1:       e.pwdata = wd[7:0] * 32'h01010101;
        2:       e.pwdata = wd[15:0] * 32'h00010001;
        default: e.pwdata = wd;
      endcase
    end else if (!e.err) begin
      v = prd >> (8 * off);
      if (nb < 4) begin
        v = v % (64'd1 << (8 * nb));
        if (f3 < 4 && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
      end
      e.rdata = v[31:0];
    end
    return e;
  endfunction

  // APB slave: PREADY after s_delay wait cycles; junk on PRDATA/PSLVERR while not ready.
  initial begin
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    forever begin
      @(negedge clk);
      if (PSEL != '0 && PENABLE) begin
        PREADY  = (s_cnt == s_delay);
        PRDATA  = PREADY ? s_prd : $urandom;
        PSLVERR = PREADY ? s_slverr : 1'($urandom_range(0, 1));
        s_cnt++;
      end else begin
        PREADY  = 1'b0;
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom_range(0, 1));
        s_cnt   = 0;
      end
    end
  end

  // Monitor: observes APB phases and pops the scoreboard on every d_done.
  initial begin
    logic        cap_apb;
    logic [3:0]  cap_psel;
    logic        cap_pwrite;
    logic [31:0] cap_paddr;
    logic [3:0]  cap_pstrb;
    logic [31:0] cap_pwdata;
    int          cap_acc;
    logic [31:0] last_rd;
    exp_t        e;
    cap_apb = 0; cap_psel = '0; cap_pwrite = 0; cap_paddr = '0; cap_pstrb = '0;
    cap_pwdata = '0; cap_acc = 0; last_rd = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cap_apb = 0; cap_acc = 0; last_rd = '0;
      end else begin
        if (PSEL != '0 && !PENABLE) begin
          cap_apb = 1; cap_psel = 4'(PSEL); cap_pwrite = PWRITE; cap_paddr = PADDR;
          cap_pstrb = PSTRB; cap_pwdata = PWDATA; cap_acc = 0;
        end else if (PSEL != '0 && PENABLE) begin
          cap_acc++;
          chk("access_psel_hold", 32'(PSEL), 32'(cap_psel));
          chk("access_paddr_hold", PADDR, cap_paddr);
        end
        if (d_done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'(d_done), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("d_err", 32'(d_err), 32'(e.err));
            chk("dRdata", dRdata, e.rdata);
            chk("latency", 32'(cyc - e.start), 32'(e.lat));
            chk("done_psel_penable", {27'h0, 4'(PSEL), PENABLE}, 32'd0);
            chk("apb_activity", 32'(cap_apb), 32'(e.apb));
            if (e.apb) begin
              chk("psel", 32'(cap_psel), 32'(e.psel));
              chk("pwrite", 32'(cap_pwrite), 32'(e.pwrite));
              chk("paddr", cap_paddr, e.paddr);
              chk("pstrb", 32'(cap_pstrb), 32'(e.pstrb));
              chk("access_cycles", 32'(cap_acc), 32'(e.acc));
              if (e.pwrite) chk("pwdata", cap_pwdata, e.pwdata);
            end
          end
          last_rd = dRdata;
          cap_apb = 0; cap_acc = 0;
        end else begin
          chk("drdata_hold", dRdata, last_rd);
        end
      end
    end
  end

  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input logic [31:0] prd, input int delay,
                        input logic serr, input logic drop);
    exp_t e;
    bit   seen;
    e = model(wr, addr, wd, f3, prd, delay, serr);
    e.start = cyc;
    s_delay = delay; s_prd = prd; s_slverr = serr;
    d_wr_en = wr; dAddr = addr; dWdata = wd; d_func3 = f3; d_req = 1'b1;
    sb.push_back(e);
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (drop) d_req = 1'b0;
      if (d_done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL done_wait actual=no_d_done required=d_done addr=%h", addr);
      sb.delete();
    end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctrl"}, {20'h0, 4'(PSEL), PENABLE, PWRITE, PSTRB, d_done, d_err}, 32'd0);
    chk({nm, "_paddr"}, PADDR, 32'd0);
    chk({nm, "_pwdata"}, PWDATA, 32'd0);
    chk({nm, "_drdata"}, dRdata, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        wr;
    logic [31:0] addr;
    logic [31:0] r;
    logic [2:0]  f3;
    logic [15:0] hi;
    int          slot;
    int          dly;
    bit          reached;
    reset = 1'b1; d_req = 1'b0; d_wr_en = 1'b0; dAddr = '0; dWdata = '0; d_func3 = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    do_txn(1'b0, 32'h1000_1004, 32'h0, F3_LW,  32'hDEADBEEF, 0, 1'b0, 1'b0);
    do_txn(1'b0, 32'h1000_0003, 32'h0, F3_LB,  32'h8012_3456, 0, 1'b0, 1'b0);
    do_txn(1'b0, 32'h1000_0003, 32'h0, F3_LBU, 32'h8012_3456, 1, 1'b0, 1'b0);
    do_txn(1'b1, 32'h1000_2002, 32'h0000_1234, F3_SH, 32'h0, 0, 1'b0, 1'b0);
    do_txn(1'b0, 32'h1000_0002, 32'h0, F3_LW,  32'h0, 0, 1'b0, 1'b0);
    do_txn(1'b0, 32'h2000_0000, 32'h0, F3_LW,  32'h0, 0, 1'b0, 1'b0);
    do_txn(1'b0, 32'h1000_3000, 32'h0, F3_LW,  32'h1111_2222, 100, 1'b0, 1'b0);
    do_txn(1'b0, 32'h1000_3000, 32'h0, F3_LW,  32'h1111_2222, TMO - 1, 1'b0, 1'b0);
    do_txn(1'b0, 32'h1000_1008, 32'h0, F3_LHU, 32'hCAFE_F00D, 2, 1'b1, 1'b0);
    do_txn(1'b0, 32'h1000_1006, 32'h0, F3_LH,  32'h9ABC_0000, 1, 1'b0, 1'b1);

    // Reset during ACCESS abandons the transfer without a completion.
    s_delay = 50; d_wr_en = 1'b0; dAddr = 32'h1000_1000; d_func3 = F3_LW; d_req = 1'b1;
    reached = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (PENABLE) begin
        reached = 1;
        break;
      end
    end
    chk("rst_reach_access", 32'(reached), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_reset");
    reset = 1'b0; d_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", 32'(d_done), 32'd0);
    end
    do_txn(1'b0, 32'h1000_3008, 32'h0, F3_LW, 32'h0BAD_C0DE, 0, 1'b0, 1'b0);

    for (int i = 0; i < 120; i++) begin
      wr   = 1'($urandom_range(0, 1));
      slot = $urandom_range(0, 5);
      hi   = ($urandom_range(0, 7) == 0) ? 16'h2000 : 16'h1000;
      r    = $urandom;
      addr = {hi, 4'(slot), r[11:0]};
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      f3   = wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      dly  = ($urandom_range(0, 9) == 0) ? int'(TMO) + 3 : $urandom_range(0, 3);
      do_txn(wr, addr, $urandom, f3, $urandom, dly,
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
